// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//  Instruction-fetch stage plus IF/ID pipeline register for the pipelined LC-3b.
//  Keeps the PC, issues one instruction-memory read at a time, and hands one
//  instruction per cycle to decode. A one-entry skid buffer absorbs a word that
//  arrives while decode is stalled. A redirect (branch/jump) flushes IF/ID and
//  restarts fetching at the new PC. A read that is already in flight is let
//  finish, and its data is thrown away.
//
//  Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   imem_read/address  read request to instruction memory (one outstanding max)
//   imem_resp/rdata    one-cycle response pulse with the instruction word
//   stall              decode cannot accept; IF/ID holds
//   redirect_valid/pc  flush and refetch from redirect_pc (bit 0 forced to 0)
//   if_valid/ir/pc     IF/ID register contents (if_valid=0 means bubble)
//   if_opcode          if_ir[15:12] for the control ROM
//   if_imm_enable      if_ir[5] for the control ROM
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   output logic [15:0] if_ir,
   output logic [15:0] if_pc,
   output logic [3:0]  if_opcode,
   output logic        if_imm_enable
);

   // HOLD    : a word is parked in the skid buffer and no request is issued.
   // DISCARD : a redirect arrived while a read was in flight. The old read
   //           finishes on its original address, and its data is dropped.
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DISCARD} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic [15:0] skid_ir_q, skid_ir_d;
   logic [15:0] skid_pc_q, skid_pc_d;
   logic        if_valid_q, if_valid_d;
   logic [15:0] if_ir_q, if_ir_d;
   logic [15:0] if_pc_q, if_pc_d;

   logic [15:0] redir_target;
   logic [15:0] req_plus2;

   assign redir_target = redirect_pc & 16'hFFFE;
   assign req_plus2    = req_addr_q + 16'd2;   // wraps modulo 2^16

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      skid_ir_d  = skid_ir_q;
      skid_pc_d  = skid_pc_q;
      if_ir_d    = if_ir_q;
      if_pc_d    = if_pc_q;
      // When decode consumes the entry, or a flush occurs, IF/ID becomes a bubble.
      // A delivery below changes it back to a valid entry.
      if_valid_d = (redirect_valid || !stall) ? 1'b0 : if_valid_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            if (redirect_valid) begin
               pc_d       = redir_target;
               req_addr_d = redir_target;
            end
         end
         S_FETCH: begin
            if (redirect_valid) begin
               pc_d = redir_target;
               if (imem_resp) begin
                  // The read completes now, so the new fetch can start immediately.
                  req_addr_d = redir_target;
               end else begin
                  state_d = S_DISCARD;
               end
            end else if (imem_resp) begin
               pc_d       = req_plus2;
               req_addr_d = req_plus2;
               if (!stall) begin
                  if_valid_d = 1'b1;
                  if_ir_d    = imem_rdata;
                  if_pc_d    = req_addr_q;
               end else begin
                  skid_ir_d = imem_rdata;
                  skid_pc_d = req_addr_q;
                  state_d   = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_d       = redir_target;
               req_addr_d = redir_target;
               state_d    = S_FETCH;
            end else if (!stall) begin
               if_valid_d = 1'b1;
               if_ir_d    = skid_ir_q;
               if_pc_d    = skid_pc_q;
               state_d    = S_FETCH;
            end
         end
         S_DISCARD: begin
            // req_addr must stay fixed until the stale read returns.
            if (redirect_valid) pc_d = redir_target;
            if (imem_resp) begin
               req_addr_d = redirect_valid ? redir_target : pc_q;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         skid_ir_q  <= 16'h0000;
         skid_pc_q  <= 16'h0000;
         if_valid_q <= 1'b0;
         if_ir_q    <= 16'h0000;
         if_pc_q    <= 16'h0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         skid_ir_q  <= skid_ir_d;
         skid_pc_q  <= skid_pc_d;
         if_valid_q <= if_valid_d;
         if_ir_q    <= if_ir_d;
         if_pc_q    <= if_pc_d;
      end
   end

   assign imem_read     = (state_q == S_FETCH) || (state_q == S_DISCARD);
   assign imem_address  = req_addr_q;
   assign if_valid      = if_valid_q;
   assign if_ir         = if_ir_q;
   assign if_pc         = if_pc_q;
   assign if_opcode     = if_ir_q[15:12];
   assign if_imm_enable = if_ir_q[5];

endmodule
